// File: rtl/lru_replacement_ctrl_pkg.sv
// lru_replacement_ctrl_pkg: shared FSM encoding, requester count and log2 helper
package lru_replacement_ctrl_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        READ,
        DECIDE,
        COMMIT
    } state_t;

    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/lru_replacement_ctrl_way_select.sv
// way_select: picks hit way, else lowest invalid way, else lowest LRU one-hot bit
module way_select
    import lru_replacement_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int WAY_BITS = log2(WIDTH)
) (
    input  logic                hit,
    input  logic [WAY_BITS-1:0] hit_way,
    input  logic [WIDTH-1:0]    valid_bits,
    input  logic [WIDTH-1:0]    lru_onehot,
    output logic [WAY_BITS-1:0] way,
    output logic                alloc
);

    logic [WAY_BITS-1:0] inv_way;
    logic [WAY_BITS-1:0] lru_way;
    logic                inv_found;

    // scan high to low so the lowest-numbered candidate wins; empty one-hot leaves way 0
    always_comb begin
        inv_way   = '0;
        lru_way   = '0;
        inv_found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!valid_bits[i]) begin
                inv_found = 1'b1;
                inv_way   = WAY_BITS'(i);
            end
            if (lru_onehot[i]) lru_way = WAY_BITS'(i);
        end
    end

    assign way   = hit ? hit_way : inv_found ? inv_way : lru_way;
    assign alloc = !hit;

endmodule

// File: rtl/lru_replacement_ctrl.sv
// lru_replacement_ctrl: arbitrates two requesters onto one LRU tracker and returns the chosen way
module lru_replacement_ctrl
    import lru_replacement_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int INDEX_BITS = 8,
    localparam int WAY_BITS = log2(WIDTH)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*INDEX_BITS-1:0] req_index,
    input  logic [NUM_REQ-1:0]            req_hit,
    input  logic [NUM_REQ*WAY_BITS-1:0]   req_hit_way,
    input  logic [NUM_REQ*WIDTH-1:0]      req_valid_bits,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [WAY_BITS-1:0]           resp_way,
    output logic                          resp_alloc,
    output logic                          init_done,
    output logic                          lru_reset,
    output logic [INDEX_BITS-1:0]         lru_index,
    output logic [WAY_BITS-1:0]           lru_access,
    output logic                          lru_access_valid,
    input  logic [WIDTH-1:0]              lru_onehot
);

    state_t                state, state_nx;
    logic [INDEX_BITS-1:0] cnt;
    logic [INDEX_BITS-1:0] cap_idx;
    logic [INDEX_BITS-1:0] last_idx;
    logic [WAY_BITS-1:0]   cap_hw;
    logic [WIDTH-1:0]      cap_vb;
    logic                  cap_hit;
    logic                  cap_g;
    logic                  last_grant;
    logic                  g;
    logic                  take;
    logic                  dec;
    logic [WAY_BITS-1:0]   sel_way;
    logic                  sel_alloc;

    // round robin: on a tie the requester that was not served last wins
    assign g    = (req_valid[0] && (!req_valid[1] || last_grant)) ? 1'b0 : 1'b1;
    assign take = (state == IDLE) && (|req_valid);
    assign dec  = (state == DECIDE);

    way_select #(.WIDTH(WIDTH)) u_sel (
        .hit        (cap_hit),
        .hit_way    (cap_hw),
        .valid_bits (cap_vb),
        .lru_onehot (lru_onehot),
        .way        (sel_way),
        .alloc      (sel_alloc)
    );

    // state register, init sweep counter and request capture
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= INIT;
            cnt        <= '0;
            last_grant <= 1'b1;
            last_idx   <= '0;
            cap_g      <= 1'b0;
            cap_idx    <= '0;
            cap_hit    <= 1'b0;
            cap_hw     <= '0;
            cap_vb     <= '0;
        end else begin
            state    <= state_nx;
            last_idx <= lru_index;
            if (state == INIT) cnt <= cnt + 1'b1;
            if (take) begin
                cap_g   <= g;
                cap_idx <= req_index[int'(g)*INDEX_BITS +: INDEX_BITS];
                cap_hit <= req_hit[g];
                cap_hw  <= req_hit_way[int'(g)*WAY_BITS +: WAY_BITS];
                cap_vb  <= req_valid_bits[int'(g)*WIDTH +: WIDTH];
            end
            if (dec) last_grant <= cap_g;
        end
    end

    // next state: sweep, then a fixed grant/read/decide/commit cycle per request
    always_comb begin
        state_nx = state;
        case (state)
            INIT:    state_nx = (cnt == '1) ? IDLE : INIT;
            IDLE:    state_nx = take ? READ : IDLE;
            READ:    state_nx = DECIDE;
            DECIDE:  state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = INIT;
        endcase
    end

    // outputs decoded from state; lru_index holds its last value outside INIT/READ/DECIDE
    always_comb begin
        lru_reset        = (state == INIT);
        init_done        = (state != INIT);
        req_ready        = take ? (NUM_REQ'(1) << g) : '0;
        resp_valid       = dec ? (NUM_REQ'(1) << cap_g) : '0;
        resp_way         = dec ? sel_way : '0;
        resp_alloc       = dec && sel_alloc;
        lru_access_valid = dec;
        lru_access       = dec ? sel_way : '0;
        lru_index        = (state == INIT) ? cnt :
                           (state == READ || dec) ? cap_idx : last_idx;
    end

endmodule

// File: doc/lru_replacement_ctrl.md
Name: lru_replacement_ctrl

Overview:
- Sequences one shared LRU tracker (one-hot `lru` output, BRAM-backed, 1-cycle read, write-back the cycle after an access) for a set-associative cache.
- Two requesters (0 = lookup pipe, 1 = refill engine) share it through a round-robin arbiter.
- Per request: reads the set's LRU state and picks the way (hit way, else lowest invalid way, else LRU way). It then issues the LRU touch and returns the way.
- After reset it sweeps every set so the tracker is fully initialised.

Parameters:
- WIDTH, 4, number of ways (power of 2, ≥2); WAY_BITS = log2(WIDTH).
- INDEX_BITS, 8, set-index width; CACHE_DEPTH = 1<<INDEX_BITS.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  request per requester.
- req_index  in  2*INDEX_BITS  set index; requester r uses slice [r*INDEX_BITS +: INDEX_BITS].
- req_hit  in  2  1 = lookup hit; use req_hit_way.
- req_hit_way  in  2*WAY_BITS  hit way per requester.
- req_valid_bits  in  2*WIDTH  per-way valid bits of the set.
- req_ready  out  2  one-cycle grant/accept pulse.
- resp_valid  out  2  one-cycle response pulse to the granted requester.
- resp_way  out  WAY_BITS  selected way; valid with resp_valid.
- resp_alloc  out  1  1 = way chosen for allocation (miss); 0 = hit touch.
- init_done  out  1  high once the post-reset sweep completes.
- lru_reset  out  1  drives tracker reset (init write).
- lru_index  out  INDEX_BITS  drives tracker current_index.
- lru_access  out  WAY_BITS  way being touched.
- lru_access_valid  out  1  touch strobe.
- lru_onehot  in  WIDTH  tracker one-hot LRU output for the addressed set.

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_way=0, resp_alloc=0, init_done=0, lru_access_valid=0, lru_access=0, lru_index=0. The FSM enters INIT with the sweep counter at 0. Reset mid-operation aborts any request; no resp_valid is issued.
- INIT: lru_reset=1, lru_index=counter, counter++ each cycle.
  - After the cycle with counter=CACHE_DEPTH-1: lru_reset=0, init_done=1, go to IDLE.
  - req_ready stays 0 throughout INIT.
- IDLE: if any req_valid, grant one requester.
  - If both are valid, grant the one that is not last_grant. last_grant resets to 1, so requester 0 wins the first tie.
  - req_ready[g]=1 for this cycle only. Capture index, hit, hit_way and valid_bits. Go to READ.
  - An ungranted requester holds req_valid and is not dropped.
- READ (T+1): lru_index=captured index; tracker read is issued. Go to DECIDE.
- DECIDE (T+2): lru_onehot is valid. Way selection:
  - Hit: way=hit_way, alloc=0.
  - Miss with any valid_bit=0: way=lowest-numbered invalid way, alloc=1.
  - Otherwise: way=lowest set bit of lru_onehot, alloc=1. If lru_onehot==0, way=0.
  - Outputs this cycle: lru_access_valid=1, lru_access=way, lru_index=captured index, resp_valid[g]=1, resp_way=way, resp_alloc=alloc. Update last_grant=g. Go to COMMIT.
- COMMIT (T+3): tracker writes back. No grant this cycle, so a same-index request cannot read stale order. Go to IDLE; the earliest next grant is T+4.
- Latency: grant→response is 2 cycles; throughput is 1 request per 4 cycles.
- req_hit_way is ignored when req_hit=0. Valid bits are ignored on a hit.
- lru_index holds its last value in IDLE/COMMIT. lru_access_valid is 1 only in DECIDE.

Decomposition:
- Shared package holds:
  - FSM state encoding: INIT, IDLE, READ, DECIDE, COMMIT.
  - Local log2 function.
  - Requester count constant NUM_REQ=2.
- One sub-module, way_select: combinational priority encoder. Inputs hit, hit_way, valid_bits, lru_onehot; outputs way and alloc. It is unit-testable in isolation.

Test Plan:
- INIT sweep: INDEX_BITS=3, release reset → lru_reset high exactly 8 cycles with lru_index 0..7; init_done rises the cycle after index 7; req_ready stays 0 during the sweep even with req_valid=2'b01.
- Hit touch: req0 idx=5, hit=1, hit_way=2 → req_ready=01 at T; lru_access_valid at T+2 with lru_access=2, lru_index=5; resp_valid=01, resp_way=2, resp_alloc=0.
- Invalid-way fill: req1 miss, valid_bits=4'b1011 → resp_way=2, resp_alloc=1 regardless of lru_onehot.
- LRU victim: all valid, tracker freshly initialised, touch ways 0,1,2 on idx 3 → fourth miss request on idx 3 sees lru_onehot=4'b1000; resp_way=3.
- Arbitration: req_valid=11 held continuously → grants alternate 01,10,01,…, spaced 4 cycles apart; no response is lost.
- Reset mid-request: assert reset during DECIDE → no further resp_valid; FSM re-enters INIT with outputs at reset values.
